// File: rtl/ex_seq_ctrl_pkg.sv
// Shared types and constants for the execute-stage sequencing controller.
// Imported by the controller and its bench.
package ex_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int TIMEOUT_DEFAULT = 64;
  localparam int CNT_W           = 8;

endpackage

// File: rtl/ex_seq_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
// Counts only when inc is high; clear takes priority over inc.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/ex_seq_ctrl.sv
// Execute-stage sequencer: single-cycle ops pass through, multi-cycle ops are
// handed to the iterative mul/div unit while EX and upstream are held.
module ex_seq_ctrl
  import ex_seq_ctrl_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic            is_multi,
  input  logic            flush,
  input  logic            mem_stall,
  input  logic            md_done,
  output logic            md_start,
  output logic            md_abort,
  output logic            ex_en,
  output logic            stall_up,
  output logic            bubble,
  output logic            err_timeout,
  output logic [XLEN-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             err_set;
  logic             start_multi;
  logic             timeout_hit;

  assign start_multi = id_valid & is_multi & ~flush;
  assign timeout_hit = (cnt == CNT_LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      err_timeout <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values of its peers.
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (err_set) begin
        err_timeout <= 1'b1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latches).
    state_nxt = state;
    cnt_nxt   = cnt;
    err_set   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!mem_stall && start_multi) begin
          state_nxt = ST_WAIT;
          cnt_nxt   = '0;
        end
      end
      ST_WAIT: begin
        cnt_nxt = cnt + CNT_W'(1);
        if (flush) begin
          state_nxt = ST_IDLE;
        end else if (md_done) begin
          state_nxt = ST_DONE;
        end else if (timeout_hit) begin
          state_nxt = ST_IDLE;
          err_set   = 1'b1;
        end
      end
      ST_DONE: begin
        if (!mem_stall) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output logic: Mealy, forced to the quiet reset pattern while rst is held
  always_comb begin
    md_start = 1'b0;
    md_abort = 1'b0;
    ex_en    = 1'b0;
    stall_up = 1'b0;
    bubble   = 1'b0;
    if (rst) begin
      bubble = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (mem_stall) begin
            stall_up = 1'b1;
          end else if (start_multi) begin
            md_start = 1'b1;
            stall_up = 1'b1;
            bubble   = 1'b1;
          end else begin
            ex_en = 1'b1;
          end
        end
        ST_WAIT: begin
          stall_up = 1'b1;
          bubble   = 1'b1;
          // A result arriving on the last allowed cycle wins over the timeout abort.
          md_abort = flush | (~md_done & timeout_hit);
        end
        ST_DONE: begin
          if (mem_stall) begin
            stall_up = 1'b1;
          end else if (flush) begin
            bubble = 1'b1;
          end else begin
            ex_en = 1'b1;
          end
        end
        default: bubble = 1'b1;
      endcase
    end
  end

  sat_counter #(.W(XLEN)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_up),
    .clear (1'b0),
    .count (stall_cnt)
  );

endmodule
